ram_sync_masked: RTL and testbench

Single-clock, byte-lane-masked synchronous RAM with a selectable read latency (1 or 2), selectable read-under-write behaviour, and a built-in clear sequencer that zero-fills the array after reset or on request. It is the next-generation single-clock storage primitive for register-file, scratchpad and data-memory use inside the core. It adds same-cycle write-to-read forwarding, a read-valid strobe, and a known-zero memory state, none of which the plain masked RAM provides.

---
 rtl/ram_sync_masked_if.sv | 28 ++
 rtl/ram_sync_masked.sv | 138 +++++++++++++
 tb/tb_ram_sync_masked.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_sync_masked_if.sv
// Bus bundle for ram_sync_masked: clear request/status, byte-lane masked
// write port and read port with a read-valid strobe.
interface ram_sync_masked_if #(
  parameter int addressWidth = 8,
  parameter int dataWidth    = 32,
  parameter int maskWidth    = 4
);
  logic                    clr_req;
  logic                    clr_busy;
  logic                    wr_en;
  logic [maskWidth-1:0]    wr_mask;
  logic [addressWidth-1:0] wr_addr;
  logic [dataWidth-1:0]    wr_data;
  logic                    rd_en;
  logic [addressWidth-1:0] rd_addr;
  logic [dataWidth-1:0]    rd_data;
  logic                    rd_valid;

  modport master (
    output clr_req, wr_en, wr_mask, wr_addr, wr_data, rd_en, rd_addr,
    input  clr_busy, rd_data, rd_valid
  );

  modport slave (
    input  clr_req, wr_en, wr_mask, wr_addr, wr_data, rd_en, rd_addr,
    output clr_busy, rd_data, rd_valid
  );
endinterface

// File: rtl/ram_sync_masked.sv
// Single-clock byte-lane masked RAM with 1- or 2-cycle read latency,
// selectable read-under-write result and a zero-fill clear sequencer.
module ram_sync_masked #(
  parameter int    addressWidth   = 8,
  parameter int    dataWidth      = 32,
  parameter int    maskWidth      = 4,
  parameter int    readLatency    = 1,
  parameter string readUnderWrite = "newData",
  parameter bit    clearOnReset   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  ram_sync_masked_if.slave  bus
);

  localparam int depth     = 2 ** addressWidth;
  localparam int laneWidth = dataWidth / maskWidth;
  localparam bit fwd_new   = (readUnderWrite == "newData");
  localparam logic [addressWidth-1:0] last_addr = '1;

  if (readLatency != 1 && readLatency != 2) begin : g_bad_latency
    $error("ram_sync_masked: readLatency must be 1 or 2");
  end
  if (dataWidth % maskWidth != 0) begin : g_bad_mask
    $error("ram_sync_masked: dataWidth must be a multiple of maskWidth");
  end
  if (readUnderWrite != "newData" && readUnderWrite != "oldData") begin : g_bad_ruw
    $error("ram_sync_masked: readUnderWrite must be newData or oldData");
  end

  typedef enum logic [1:0] {
    ST_RESET,
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [addressWidth-1:0] clr_addr_q;
  logic                    clr_busy;
  logic                    access_ok;
  logic                    wr_accept;
  logic                    rd_accept;
  logic [dataWidth-1:0]    rd_word;
  logic [dataWidth-1:0]    rd_data_q;
  logic                    rd_valid_q;

  logic [dataWidth-1:0]    mem [depth];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET: state_d = clearOnReset ? ST_CLEAR : ST_READY;
      ST_CLEAR: if (clr_addr_q == last_addr) state_d = ST_READY;
      ST_READY: if (bus.clr_req) state_d = ST_CLEAR;
      default:  state_d = ST_RESET;
    endcase
  end

  // A clr_req in READY wins over any same-cycle access.
  always_comb begin
    clr_busy  = (state_q == ST_CLEAR);
    access_ok = (state_q == ST_READY) && !bus.clr_req && !reset;
    wr_accept = access_ok && bus.wr_en;
    rd_accept = access_ok && bus.rd_en;
  end

  // Wraps back to zero after the last address, ready for the next clear.
  always_ff @(posedge clk) begin
    if (reset)         clr_addr_q <= '0;
    else if (clr_busy) clr_addr_q <= clr_addr_q + addressWidth'(1);
  end

  // NOTE: the array has no reset; the clear sequencer provides the known-zero state.
  always_ff @(posedge clk) begin
    if (clr_busy && !reset) begin
      mem[clr_addr_q] <= '0;
    end else if (wr_accept) begin
      for (int i = 0; i < maskWidth; i++) begin
        if (bus.wr_mask[i])
          mem[bus.wr_addr][i*laneWidth +: laneWidth] <= bus.wr_data[i*laneWidth +: laneWidth];
      end
    end
  end

  // Stored word, with written lanes forwarded when the read sees new data.
  always_comb begin
    rd_word = mem[bus.rd_addr];
    if (fwd_new && wr_accept && (bus.wr_addr == bus.rd_addr)) begin
      for (int i = 0; i < maskWidth; i++) begin
        if (bus.wr_mask[i])
          rd_word[i*laneWidth +: laneWidth] = bus.wr_data[i*laneWidth +: laneWidth];
      end
    end
  end

  if (readLatency == 2) begin : g_lat2
    logic [dataWidth-1:0] s1_data_q;
    logic                 s1_valid_q;

    // The output stage advances in every state so an in-flight read finishes during CLEAR.
    always_ff @(posedge clk) begin
      if (reset) begin
        s1_data_q  <= '0;
        s1_valid_q <= 1'b0;
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        s1_valid_q <= rd_accept;
        if (rd_accept) s1_data_q <= rd_word;
        rd_valid_q <= s1_valid_q;
        if (s1_valid_q) rd_data_q <= s1_data_q;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_accept;
        if (rd_accept) rd_data_q <= rd_word;
      end
    end
  end

  assign bus.clr_busy = clr_busy;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_sync_masked.sv
// Self-checking bench: two instances (latency 1 / newData, latency 2 / oldData)
// share one stimulus stream and are compared each cycle to a behavioural model.
module tb_ram_sync_masked;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int N  = 2 ** AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_sync_masked_if #(.addressWidth(AW), .dataWidth(DW), .maskWidth(MW)) bus_a ();
  ram_sync_masked_if #(.addressWidth(AW), .dataWidth(DW), .maskWidth(MW)) bus_b ();

  assign bus_b.clr_req = bus_a.clr_req;
  assign bus_b.wr_en   = bus_a.wr_en;
  assign bus_b.wr_mask = bus_a.wr_mask;
  assign bus_b.wr_addr = bus_a.wr_addr;
  assign bus_b.wr_data = bus_a.wr_data;
  assign bus_b.rd_en   = bus_a.rd_en;
  assign bus_b.rd_addr = bus_a.rd_addr;

  ram_sync_masked #(
    .addressWidth(AW), .dataWidth(DW), .maskWidth(MW),
    .readLatency(1), .readUnderWrite("newData"), .clearOnReset(1'b1)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  ram_sync_masked #(
    .addressWidth(AW), .dataWidth(DW), .maskWidth(MW),
    .readLatency(2), .readUnderWrite("oldData"), .clearOnReset(1'b1)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory array, clear countdown and the read result stream.
  logic [DW-1:0] mmem [N];
  bit            live = 1'b0;
  bit            in_reset;
  int            clear_left;
  bit            exp_busy;
  bit            exp_a_v, exp_b_v, pend_v;
  logic [DW-1:0] exp_a_d, exp_b_d, pend_d;

  always @(posedge clk) begin : model
    bit            rd, wr;
    logic [DW-1:0] old_w, new_w, merged;
    rd = 1'b0;
    wr = 1'b0;
    if (reset) begin
      live       = 1'b1;
      in_reset   = 1'b1;
      clear_left = 0;
      pend_v     = 1'b0;
      pend_d     = '0;
      exp_a_v    = 1'b0;
      exp_a_d    = '0;
      exp_b_v    = 1'b0;
      exp_b_d    = '0;
    end else if (live) begin
      if (in_reset) begin
        in_reset   = 1'b0;
        clear_left = N;
      end else if (clear_left > 0) begin
        mmem[N - clear_left] = '0;
        clear_left--;
      end else if (bus_a.clr_req) begin
        clear_left = N;
      end else begin
        rd = bus_a.rd_en;
        wr = bus_a.wr_en;
      end
      merged = mmem[bus_a.wr_addr];
      for (int i = 0; i < MW; i++)
        if (bus_a.wr_mask[i]) merged[8*i +: 8] = bus_a.wr_data[8*i +: 8];
      old_w = mmem[bus_a.rd_addr];
      new_w = (wr && bus_a.wr_addr == bus_a.rd_addr) ? merged : old_w;
      exp_a_v = rd;
      if (rd) exp_a_d = new_w;
      exp_b_v = pend_v;
      if (pend_v) exp_b_d = pend_d;
      pend_v = rd;
      if (rd) pend_d = old_w;
      if (wr) mmem[bus_a.wr_addr] = merged;
    end
    exp_busy = (clear_left > 0);
  end

  always @(negedge clk) begin
    if (live) begin
      check("a_clr_busy", 32'(bus_a.clr_busy), 32'(exp_busy));
      check("b_clr_busy", 32'(bus_b.clr_busy), 32'(exp_busy));
      check("a_rd_valid", 32'(bus_a.rd_valid), 32'(exp_a_v));
      check("b_rd_valid", 32'(bus_b.rd_valid), 32'(exp_b_v));
      check("a_rd_data",  bus_a.rd_data, exp_a_d);
      check("b_rd_data",  bus_b.rd_data, exp_b_d);
    end
  end

  task automatic idle();
    bus_a.clr_req = 1'b0;
    bus_a.wr_en   = 1'b0;
    bus_a.wr_mask = '0;
    bus_a.wr_addr = '0;
    bus_a.wr_data = '0;
    bus_a.rd_en   = 1'b0;
    bus_a.rd_addr = '0;
  endtask

  // All access tasks start and end on a falling edge with idle inputs.
  task automatic write_word(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [MW-1:0] mask);
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = addr;
    bus_a.wr_data = data;
    bus_a.wr_mask = mask;
    @(negedge clk);
    idle();
  endtask

  task automatic rd_pair(input logic [AW-1:0] addr, input logic [DW-1:0] exp_a,
                         input logic [DW-1:0] exp_b, input string name);
    bus_a.rd_en   = 1'b1;
    bus_a.rd_addr = addr;
    @(negedge clk);
    idle();
    check({name, "_a_valid"}, 32'(bus_a.rd_valid), 32'd1);
    check({name, "_a_data"}, bus_a.rd_data, exp_a);
    @(negedge clk);
    check({name, "_b_valid"}, 32'(bus_b.rd_valid), 32'd1);
    check({name, "_b_data"}, bus_b.rd_data, exp_b);
  endtask

  task automatic wait_clear(input string name);
    int count = 0;
    for (int i = 0; i < 64; i++) begin
      if (bus_a.clr_busy) count++;
      else if (count > 0) break;
      @(negedge clk);
    end
    check(name, 32'(count), 32'(N));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_seen;
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    check("reset_rd_data_a", bus_a.rd_data, 32'h0);
    check("reset_rd_valid_b", 32'(bus_b.rd_valid), 32'd0);
    reset = 1'b0;
    wait_clear("boot_clear_len");

    // Reset-triggered zero fill over garbage contents.
    for (int i = 0; i < N; i++) write_word(AW'(i), $urandom() | 32'h1, 4'hF);
    pulse_reset();
    wait_clear("reset_clear_len");
    for (int i = 0; i < N; i++) rd_pair(AW'(i), 32'h0, 32'h0, $sformatf("zero%0d", i));

    // Masked write merge.
    write_word(4'd3, 32'hAABBCCDD, 4'b1111);
    write_word(4'd3, 32'h11223344, 4'b0101);
    rd_pair(4'd3, 32'hAA22CC44, 32'hAA22CC44, "masked");

    // Read-under-write: newData on instance a, oldData on instance b.
    write_word(4'd5, 32'hDEADBEEF, 4'b1111);
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 4'd5; bus_a.wr_data = 32'h12345678;
    bus_a.wr_mask = 4'b0011; bus_a.rd_en = 1'b1; bus_a.rd_addr = 4'd5;
    @(negedge clk);
    idle();
    check("ruw_new", bus_a.rd_data, 32'hDEAD5678);
    @(negedge clk);
    check("ruw_old", bus_b.rd_data, 32'hDEADBEEF);
    rd_pair(4'd5, 32'hDEAD5678, 32'hDEAD5678, "ruw_after");

    // Back-to-back reads at both latencies.
    for (int i = 0; i < 4; i++) write_word(AW'(i), 32'h10 + 32'(i), 4'hF);
    for (int t = 0; t < 7; t++) begin
      check($sformatf("b2b_a_valid%0d", t), 32'(bus_a.rd_valid), 32'(t >= 1 && t <= 4));
      check($sformatf("b2b_b_valid%0d", t), 32'(bus_b.rd_valid), 32'(t >= 2 && t <= 5));
      if (t >= 1 && t <= 4) check($sformatf("b2b_a_data%0d", t), bus_a.rd_data, 32'h10 + 32'(t - 1));
      if (t >= 2 && t <= 5) check($sformatf("b2b_b_data%0d", t), bus_b.rd_data, 32'h10 + 32'(t - 2));
      if (t < 4) begin
        bus_a.rd_en = 1'b1;
        bus_a.rd_addr = AW'(t);
      end else begin
        idle();
      end
      @(negedge clk);
    end

    // Reset in the middle of a requested clear.
    for (int i = 0; i < N; i++) write_word(AW'(i), 32'hA5A50000 | 32'(i), 4'hF);
    bus_a.clr_req = 1'b1;
    @(negedge clk);
    idle();
    busy_seen = 0;
    for (int i = 0; i < 32 && busy_seen < 7; i++) begin
      if (bus_a.clr_busy) busy_seen++;
      if (busy_seen < 7) @(negedge clk);
    end
    check("midclear_reached7", 32'(busy_seen), 32'd7);
    reset = 1'b1;
    @(negedge clk);
    check("midclear_abort", 32'(bus_a.clr_busy), 32'd0);
    reset = 1'b0;
    wait_clear("midclear_restart_len");
    for (int i = 0; i < N; i++) rd_pair(AW'(i), 32'h0, 32'h0, $sformatf("mid%0d", i));

    // clr_req collides with a write and a read: both dropped.
    write_word(4'd7, 32'h0BADF00D, 4'hF);
    bus_a.clr_req = 1'b1; bus_a.wr_en = 1'b1; bus_a.wr_addr = 4'd2;
    bus_a.wr_data = 32'hFFFFFFFF; bus_a.wr_mask = 4'hF;
    bus_a.rd_en = 1'b1; bus_a.rd_addr = 4'd7;
    @(negedge clk);
    idle();
    check("collide_no_valid", 32'(bus_a.rd_valid), 32'd0);
    wait_clear("collide_clear_len");
    rd_pair(4'd2, 32'h0, 32'h0, "collide_addr2");

    // Randomised traffic with occasional clears and resets.
    for (int c = 0; c < 2000; c++) begin
      reset         = ($urandom_range(0, 399) == 0);
      bus_a.clr_req = ($urandom_range(0, 99) == 0);
      bus_a.wr_en   = $urandom_range(0, 1) == 1;
      bus_a.wr_mask = MW'($urandom());
      bus_a.wr_addr = AW'($urandom());
      bus_a.wr_data = $urandom();
      bus_a.rd_en   = $urandom_range(0, 2) != 0;
      bus_a.rd_addr = ($urandom_range(0, 1) == 1) ? bus_a.wr_addr : AW'($urandom());
      @(negedge clk);
    end
    reset = 1'b0;
    idle();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
